// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port arbiter: core writebacks win, accelerator results queue in a small FIFO.
// Optional macro WB_STALL_CNT_EN adds a saturating stall_cycles counter output.
module rf_writeback_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          core_wb_valid,
  input  logic [ADDR_W-1:0]             core_wb_rd,
  input  logic [DATA_W-1:0]             core_wb_data,
  input  logic                          acc_wb_valid,
  output logic                          acc_wb_ready,
  input  logic [ADDR_W-1:0]             acc_wb_rd,
  input  logic [DATA_W-1:0]             acc_wb_data,
  output logic                          regwrite,
  output logic [ADDR_W-1:0]             write_reg,
  output logic [DATA_W-1:0]             write_data,
  output logic [31:0]                   pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]     r_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0]     r_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_valid;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  r_regwrite;
  logic [ADDR_W-1:0]     r_write_reg;
  logic [DATA_W-1:0]     r_write_data;

  logic                  w_core_wr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_valid;
  logic                  w_acc_wr;
  logic [31:0]           w_entry_mask [FIFO_DEPTH];
  logic [31:0]           w_pending;

  assign w_core_wr    = core_wb_valid && (core_wb_rd != '0);
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = acc_wb_valid && !w_full;
  assign w_head_valid = r_valid[r_rd_ptr];
  // A squashed/x0 head is discarded even while the core owns the port.
  assign w_pop        = !w_empty && (!w_head_valid || !w_core_wr);
  assign w_acc_wr     = !w_empty && w_head_valid && !w_core_wr;

  assign acc_wb_ready = !w_full;
  assign regwrite     = r_regwrite;
  assign write_reg    = r_write_reg;
  assign write_data   = r_write_data;
  assign fifo_count   = r_count;
  assign pending_mask = w_pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Push and pop never target the same slot: they coincide only when empty or full.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_push && (r_wr_ptr == PTR_W'(i)))
          r_valid[i] <= (acc_wb_rd != '0);
        else if (w_pop && (r_rd_ptr == PTR_W'(i)))
          r_valid[i] <= 1'b0;
        else if (w_core_wr && (r_rd[i] == core_wb_rd))
          r_valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_rd[r_wr_ptr]   <= acc_wb_rd;
      r_data[r_wr_ptr] <= acc_wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_regwrite <= w_core_wr || w_acc_wr;
      if (w_core_wr) begin
        r_write_reg  <= core_wb_rd;
        r_write_data <= core_wb_data;
      end else if (w_acc_wr) begin
        r_write_reg  <= r_rd[r_rd_ptr];
        r_write_data <= r_data[r_rd_ptr];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry_mask
      assign w_entry_mask[gi] = r_valid[gi] ? (32'd1 << r_rd[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      w_pending = w_pending | w_entry_mask[i];
  end

`ifdef WB_STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clock) begin
    if (reset)
      r_stall_cycles <= '0;
    else if (!w_empty && w_head_valid && w_core_wr && (r_stall_cycles != 16'hFFFF))
      r_stall_cycles <= r_stall_cycles + 16'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
Write-side controller for the core's 32x32 register file: sole driver of regwrite/write_reg/write_data.
Merges two writeback producers: the core pipeline (highest priority, never stalled) and the kNN accelerator (valid/ready, buffered in a small FIFO).
Enforces x0 write suppression and write-after-write ordering between the two producers.
Exports a pending-write mask so the core can interlock reads of registers with queued accelerator results.

Parameters:
FIFO_DEPTH, 4, accelerator writeback FIFO entries (power of 2, >=2)
DATA_W, 32, register data width
ADDR_W, 5, register index width

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
core_wb_valid  input  1  core writeback this cycle
core_wb_rd  input  ADDR_W  core destination register
core_wb_data  input  DATA_W  core writeback data
acc_wb_valid  input  1  accelerator writeback request
acc_wb_ready  output  1  FIFO can accept (combinational: count != FIFO_DEPTH)
acc_wb_rd  input  ADDR_W  accelerator destination register
acc_wb_data  input  DATA_W  accelerator result
regwrite  output  1  register-file write enable (registered)
write_reg  output  ADDR_W  register-file write index (registered)
write_data  output  DATA_W  register-file write data (registered)
pending_mask  output  32  bit r set = live (unsquashed) FIFO entry targets xr
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries, squashed entries included

Behaviour:
- Reset (sync, clock edge with reset=1): regwrite=0, write_reg=0, write_data=0, FIFO empty, all entry valid bits 0, pending_mask=0, fifo_count=0. Reset overrides all same-cycle requests; queued entries are discarded, never written.
- Latency: 1 cycle. A request selected at edge N appears on regwrite/write_reg/write_data after edge N; the register file samples it at edge N+1.
- Core path: core_wb_valid=1 with core_wb_rd!=0 issues the core write. Core always wins the write port.
- Core write to x0: no write issued (regwrite=0). The port counts as free that cycle, so the FIFO may drain.
- Accelerator enqueue: handshake = acc_wb_valid & acc_wb_ready.
  - Entry stores {rd, data, valid}.
  - valid=0 when acc_wb_rd=0, so x0 writes are accepted but never performed.
  - No enqueue when full; producer holds its request until ready.
- Dequeue: head is examined every cycle the FIFO is non-empty.
  - Head valid=1: popped and written only when the port is free (core_wb_valid=0 or core_wb_rd=0).
  - Head valid=0 (squashed or x0): popped without issuing a write, regardless of core activity.
  - At most one pop per cycle.
- Simultaneous enqueue and pop: both occur; fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- WAW ordering: a core write to rd!=0 clears valid on every FIFO entry already holding that rd, at the same edge.
  - An accelerator entry enqueued in the same cycle as the core write is newer and is not squashed.
- pending_mask: combinational OR of one-hot(rd) over all entries with valid=1. It updates the cycle after enqueue, squash or pop.
- No state machine beyond the FIFO. Outputs are idle (regwrite=0) when nothing is issued; write_reg/write_data hold their last value.

Optional Feature:
WB_STALL_CNT_EN
- Defined: adds output stall_cycles[15:0].
  - Reset 0.
  - Increments (saturating at 16'hFFFF) every cycle the FIFO head has valid=1 but is blocked by a core write to rd!=0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then idle -> regwrite=0, write_reg=0, write_data=0, acc_wb_ready=1, fifo_count=0, pending_mask=0.
- Core write x5=32'hDEADBEEF at cycle N -> cycle N+1: regwrite=1, write_reg=5, write_data=32'hDEADBEEF; cycle N+2: regwrite=0.
- Core valid (rd=3) every cycle; accelerator pushes x8..x11 = 1..4.
  - After 4 handshakes: acc_wb_ready=0, fifo_count=4, pending_mask=32'h00000F00.
  - Drop core_wb_valid: four consecutive writes x8=1, x9=2, x10=3, x11=4 in order; count returns to 0, mask returns to 0.
- Core write rd=0 -> regwrite stays 0. Accelerator push x0=32'h55 -> accepted (fifo_count 1), pending_mask=0, popped next free cycle with no write.
- Core busy on x1; accelerator pushes x7=32'h11 -> pending_mask bit7=1.
  - Core then writes x7=32'h22 -> bit7 clears.
  - After drain, only 32'h22 was ever written to x7.
- 3 entries queued, assert reset for one cycle -> fifo_count=0, pending_mask=0, no further regwrite pulses.
  - With WB_STALL_CNT_EN defined: stall_cycles=0 after reset.
